// File: rtl/tpu_uart_host_if.sv
// Request/response handshake between on-chip control logic and the TPU UART host.
// The master side issues commands; the slave side (the host block) returns one result per command.
`timescale 1ns/1ps
interface tpu_uart_host_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_cmd;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;

  modport master (
    output req_valid, req_cmd, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/tpu_uart_host.sv
// Host-side initiator for the TPU UART command protocol: serialises one request into
// command bytes, then waits for and checks the single response byte.
`timescale 1ns/1ps
module tpu_uart_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic             clk,
  input  logic             rst,
  tpu_uart_host_if.slave   host,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic [7:0]       stray_count
);
  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_Q = 8'h3F;

  typedef enum logic [2:0] {IDLE, SEND, TX_WAIT, WAIT_RSP, DONE} state_t;

  state_t        state;
  logic [7:0]    cmd_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [1:0]    num_bytes;
  logic [1:0]    sent;
  logic          tx_settle;
  logic [CW-1:0] cnt;

  logic [1:0]    req_len;
  logic [7:0]    next_byte;
  logic          rsp_ok;

  // Zero length marks an illegal command.
  always_comb begin
    req_len = 2'd0;
    case (host.req_cmd)
      CMD_W, CMD_A: req_len = 2'd3;
      CMD_R:        req_len = 2'd2;
      CMD_S, CMD_Q: req_len = 2'd1;
      default:      req_len = 2'd0;
    endcase
  end

  always_comb begin
    case (sent)
      2'd0:    next_byte = cmd_q;
      2'd1:    next_byte = addr_q;
      default: next_byte = data_q;
    endcase
  end

  always_comb begin
    rsp_ok = 1'b1;
    case (cmd_q)
      CMD_W, CMD_A, CMD_S: rsp_ok = (rx_data == ACK_BYTE);
      CMD_Q:               rsp_ok = (rx_data[7:2] == 6'd0);
      default:             rsp_ok = 1'b1;
    endcase
  end

  // tx_settle skips the first TX_WAIT cycle, before the transmitter can have raised tx_busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd_q           <= 8'h00;
      addr_q          <= 8'h00;
      data_q          <= 8'h00;
      num_bytes       <= 2'd0;
      sent            <= 2'd0;
      tx_settle       <= 1'b0;
      cnt             <= '0;
      tx_data         <= 8'h00;
      tx_start        <= 1'b0;
      busy            <= 1'b0;
      stray_count     <= 8'h00;
      host.req_ready  <= 1'b0;
      host.rsp_valid  <= 1'b0;
      host.rsp_data   <= 8'h00;
      host.rsp_status <= 2'b00;
    end else begin
      tx_start       <= 1'b0;
      host.rsp_valid <= 1'b0;
      if (rx_valid && state != WAIT_RSP && stray_count != 8'hFF)
        stray_count <= stray_count + 8'd1;

      case (state)
        IDLE: begin
          host.req_ready <= 1'b1;
          if (host.req_valid && host.req_ready) begin
            host.req_ready <= 1'b0;
            busy           <= 1'b1;
            cmd_q          <= host.req_cmd;
            addr_q         <= host.req_addr;
            data_q         <= host.req_data;
            num_bytes      <= req_len;
            sent           <= 2'd0;
            if (req_len == 2'd0) begin
              host.rsp_valid  <= 1'b1;
              host.rsp_status <= 2'b11;
              host.rsp_data   <= 8'h00;
              state           <= DONE;
            end else if (!tx_busy) begin
              tx_data   <= host.req_cmd;
              tx_start  <= 1'b1;
              sent      <= 2'd1;
              tx_settle <= 1'b1;
              state     <= TX_WAIT;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data   <= next_byte;
            tx_start  <= 1'b1;
            sent      <= sent + 2'd1;
            tx_settle <= 1'b1;
            state     <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_settle) begin
            tx_settle <= 1'b0;
          end else if (!tx_busy) begin
            if (sent == num_bytes) begin
              cnt   <= '0;
              state <= WAIT_RSP;
            end else begin
              state <= SEND;
            end
          end
        end
        // A byte arriving on the expiry cycle takes priority over the timeout.
        WAIT_RSP: begin
          cnt <= cnt + 1'b1;
          if (rx_valid) begin
            host.rsp_data   <= rx_data;
            host.rsp_status <= rsp_ok ? 2'b00 : 2'b01;
            host.rsp_valid  <= 1'b1;
            state           <= DONE;
          end else if (cnt == LAST_CNT) begin
            host.rsp_data   <= 8'h00;
            host.rsp_status <= 2'b10;
            host.rsp_valid  <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          busy           <= 1'b0;
          host.req_ready <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tpu_uart_host.md
Name: tpu_uart_host

Overview:
- Host-side initiator for the TPU UART command protocol. It turns one parallel request into the command byte sequence and then collects the single response byte.
- It sits between on-chip control logic (self-test sequencer, loopback bench, a second FPGA) and a byte-level UART TX/RX pair.
- It checks each response (ACK, status format, timeout) and reports one result per request.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, clocks allowed from the end of the last transmitted byte to the response byte.
- ACK_BYTE, 8'h06, acknowledge value expected for W/A/S.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_cmd  in  8  command: 8'h57 'W', 8'h41 'A', 8'h53 'S', 8'h52 'R', 8'h3F '?'
- req_addr  in  8  address byte (W/A/R)
- req_data  in  8  data byte (W/A)
- tx_data  out  8  byte to UART transmitter
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_busy  in  1  transmitter busy; must be high the cycle after tx_start
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rsp_valid  out  1  one-cycle pulse, result available
- rsp_data  out  8  response byte (R: read data; ?: status; W/A/S: received byte)
- rsp_status  out  2  00 OK, 01 bad response, 10 timeout, 11 illegal command
- busy  out  1  request in progress
- stray_count  out  8  saturating count of rx bytes received outside WAIT_RSP

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-high reset rst. While rst is high, all outputs are 0, req_ready is 0, and the FSM is in IDLE. req_ready rises on the first clk edge after rst falls.
- Request acceptance: a request is accepted on a cycle where req_valid and req_ready are both 1. req_cmd, req_addr and req_data are latched on that cycle. req_ready is 1 only in IDLE.
- Byte sequences:
  - W and A send cmd, addr, data.
  - R sends cmd, addr.
  - S and ? send cmd only.
- Illegal command:
  - Any other req_cmd sends no bytes.
  - rsp_valid is pulsed the cycle after acceptance with rsp_status = 11 and rsp_data = 0.
  - The FSM returns to IDLE.
- FSM states: IDLE, SEND, TX_WAIT, WAIT_RSP, DONE.
  - SEND: if tx_busy = 0, drive tx_data with the current byte, pulse tx_start for 1 cycle, go to TX_WAIT. Otherwise stay in SEND.
  - TX_WAIT: wait at least one cycle, then wait for tx_busy = 0. If more bytes remain, go to SEND for the next byte; otherwise go to WAIT_RSP with the timeout counter cleared.
  - First tx_start is asserted the cycle after acceptance if tx_busy = 0.
  - WAIT_RSP: counter increments each cycle.
    - If rx_valid: capture rx_data into rsp_data and go to DONE.
    - Else if counter reaches TIMEOUT_CYCLES-1: rsp_data = 0, rsp_status = 10, go to DONE.
    - If rx_valid and expiry occur in the same cycle, the byte wins.
  - DONE: pulse rsp_valid for 1 cycle, return to IDLE. req_ready is 1 on the next cycle.
- Response checking:
  - W, A, S: OK only if rx_data == ACK_BYTE, else 01.
  - ?: OK only if rx_data[7:2] == 0, else 01.
  - R: any byte is OK.
- Stray bytes: an rx_valid in any state other than WAIT_RSP is dropped and increments stray_count. stray_count saturates at 255 and is cleared only by rst.
- busy: 1 from the cycle after acceptance through the DONE cycle.
- Reset mid-operation: the transfer is abandoned, nothing is pulsed, and no rsp_valid is issued for it.
- Counter width: clog2(TIMEOUT_CYCLES).

Test Plan:
- W, addr 8'h10, data 8'hA5; TX model returns ACK 8'h06 -> tx bytes 57,10,A5 in order, tx_start pulses exactly 3; rsp_valid with status 00, rsp_data 06.
- R, addr 8'h03; RX returns 8'h7E -> tx bytes 52,03; rsp_data 7E, status 00.
- ?; RX returns 8'h02 -> status 00, rsp_data 02. ?; RX returns 8'hC1 -> status 01.
- S with no reply, TIMEOUT_CYCLES = 50 -> rsp_valid exactly 50 cycles after tx_busy falls on the last byte, status 10. Repeat with rx_valid on the expiry cycle -> status 00 if the byte is 06.
- req_cmd 8'h00 -> no tx_start; rsp_valid the next cycle with status 11. Separately, 3 rx_valid pulses while IDLE -> stray_count 3 and no rsp_valid.
- Assert rst during TX_WAIT of a W -> outputs 0 asynchronously; no rsp_valid; after release the next A request completes with status 00.
